// File: rtl/stopwatch_display_driver.sv
// Stopwatch 4-digit common-anode 7-seg display driver.
// Scans shadowed BCD digits with anti-ghost blanking and adjust-field blink.
module stopwatch_display_driver #(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BLINK_DIV    = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] m10,
  input  logic [3:0] m1,
  input  logic [2:0] s10,
  input  logic [3:0] s1,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [6:0]    DASH       = 7'b0111111;

  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    idx_q, idx_d;
  logic          first_q;
  logic          scan_wrap;
  logic          snap;

  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;

  logic [2:0]    sh_m10_q, sh_s10_q;
  logic [3:0]    sh_m1_q, sh_s1_q;

  logic [3:0]    digit;
  logic          tens;
  logic          active;
  logic          suppress;
  logic          lit;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  function automatic logic [6:0] seg7(
    input logic [3:0] d,
    input logic       t
  );
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = DASH;
    endcase
    if (t && (d > 4'd5)) s = DASH;
    return s;
  endfunction

  // Scan slot timing and snapshot strobe
  always_comb begin
    scan_wrap = (scan_q == SCAN_LAST);
    scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
    idx_d     = scan_wrap ? idx_q + 2'd1 : idx_q;
    snap      = first_q | (scan_wrap & (idx_q == 2'd3));
  end

  // Blink half-period counter, cleared outside adjust mode
  always_comb begin
    blink_d = '0;
    phase_d = 1'b0;
    if (adj) begin
      if (blink_q == BLINK_LAST) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + 1'b1;
        phase_d = phase_q;
      end
    end
  end

  // Digit select from the shadows, tens zero-extended
  always_comb begin
    digit = sh_s1_q;
    tens  = 1'b0;
    unique case (idx_q)
      2'd0: begin digit = sh_s1_q;          tens = 1'b0; end
      2'd1: begin digit = {1'b0, sh_s10_q}; tens = 1'b1; end
      2'd2: begin digit = sh_m1_q;          tens = 1'b0; end
      2'd3: begin digit = {1'b0, sh_m10_q}; tens = 1'b1; end
      default: ;
    endcase
  end

  // Next output values: blanking, blink suppression, decode
  always_comb begin
    active   = (scan_q >= BLANK_END);
    suppress = adj & phase_q & (sel ? ~idx_q[1] : idx_q[1]);
    lit      = active & ~suppress;
    an_d     = lit ? ~(4'b0001 << idx_q) : 4'b1111;
    dp_d     = ~(lit & (idx_q == 2'd2));
    seg_d    = seg7(digit, tens);
  end

  // Scan counter, digit index and first-capture flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_q  <= '0;
      idx_q   <= 2'd0;
      first_q <= 1'b1;
    end else begin
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      first_q <= 1'b0;
    end
  end

  // Blink counter and phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_q <= '0;
      phase_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
      phase_q <= phase_d;
    end
  end

  // Frame-aligned snapshot of the input digits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_m10_q <= '0;
      sh_m1_q  <= '0;
      sh_s10_q <= '0;
      sh_s1_q  <= '0;
    end else if (snap) begin
      sh_m10_q <= m10;
      sh_m1_q  <= m1;
      sh_s10_q <= s10;
      sh_s1_q  <= s1;
    end
  end

  // Registered display outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_stopwatch_display_driver.sv
// Directed bench for stopwatch_display_driver.
// Small-parameter instance: 8-cycle slots, 2 blank, 20-cycle blink.
module tb_stopwatch_display_driver;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] m10, s10;
  logic [3:0] m1, s1;
  logic       adj, sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_run  = 0;
  int n_fail = 0;
  int st     = 0;
  int adj_st = 0;

  logic [3:0][6:0] f_a, f_b, f_d, f_n;

  stopwatch_display_driver #(
    .SCAN_DIV    (8),
    .BLANK_CYCLES(2),
    .BLINK_DIV   (20)
  ) dut (
    .clk(clk), .rst(rst),
    .m10(m10), .m1(m1), .s10(s10), .s1(s1),
    .adj(adj), .sel(sel),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs,
                     input logic [6:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s st=%0d observed=%b expected=%b", tag, st, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    st++;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_an"}, {3'b0, an}, 7'b0001111);
    chk({tag, "_seg"}, seg, 7'b1111111);
    chk({tag, "_dp"}, {6'b0, dp}, 7'b0000001);
  endtask

  function automatic logic [3:0] blink_mask();
    if (adj && (((st - adj_st) / 20) % 2 == 1))
      return sel ? 4'b0011 : 4'b1100;
    return 4'b0000;
  endfunction

  task automatic check_cycle(input logic [3:0][6:0] segs);
    int pos;
    int idx;
    logic [3:0] sup;
    logic [3:0] ea;
    logic       ed;
    pos = st % 8;
    idx = (st / 8) % 4;
    sup = blink_mask();
    if (pos < 2) begin
      chk("blank_an", {3'b0, an}, 7'b0001111);
      chk("blank_dp", {6'b0, dp}, 7'b0000001);
    end else begin
      ea = sup[idx] ? 4'b1111 : ~(4'b0001 << idx);
      ed = (idx == 2 && !sup[idx]) ? 1'b0 : 1'b1;
      chk("scan_an", {3'b0, an}, {3'b0, ea});
      chk("scan_dp", {6'b0, dp}, {6'b0, ed});
      if (!sup[idx]) chk("scan_seg", seg, segs[idx]);
    end
  endtask

  task automatic run(input int cycles, input logic [3:0][6:0] segs);
    for (int i = 0; i < cycles; i++) begin
      tick();
      check_cycle(segs);
    end
  endtask

  initial begin
    f_a = {S1, S2, S3, S4};
    f_b = {S1, S2, S3, S9};
    f_d = {SD, S2, S3, SD};
    f_n = {S5, S9, S0, S7};
    rst = 1'b0;
    m10 = 3'd1; m1 = 4'd2; s10 = 3'd3; s1 = 4'd4;
    adj = 1'b0; sel = 1'b1;

    repeat (5) begin
      tick();
      check_reset("rst_hold");
    end
    rst = 1'b1;
    st  = -1;
    run(8, f_a);

    #2 rst = 1'b0;
    #1 check_reset("rst_async");
    tick();
    check_reset("rst_async_hold");
    rst = 1'b1;
    st  = -1;

    run(64, f_a);

    for (int i = 0; i < 32; i++) begin
      tick();
      check_cycle(f_a);
      if (st == 73) s1 = 4'd9;
    end
    run(32, f_b);

    s1  = 4'd12;
    m10 = 3'd7;
    run(32, f_b);
    run(32, f_d);

    adj    = 1'b1;
    sel    = 1'b1;
    adj_st = st + 1;
    run(80, f_d);
    sel = 1'b0;
    run(80, f_d);
    adj = 1'b0;
    run(32, f_d);

    run(22, f_d);
    #2 rst = 1'b0;
    #1 check_reset("rst_mid");
    m10 = 3'd5; m1 = 4'd9; s10 = 3'd0; s1 = 4'd7;
    repeat (2) begin
      tick();
      check_reset("rst_mid_hold");
    end
    rst = 1'b1;
    st  = -1;
    run(32, f_n);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
